pipeline_hazard_controller: RTL and testbench

Parametrised successor to the fixed two-stage hazard detector of the 5-stage ARM core. It keeps its own in-flight scoreboard of writebacks for DEPTH post-ID slots (EXE, MEM, WB, …) and produces the following:
- stall and bubble control;
- optional operand-forwarding selects;
- a global freeze for a multi-cycle data memory.
It sits at the core top, between the ID stage and the IF/ID/EXE/MEM pipeline registers.

---
 rtl/pipeline_hazard_controller_if.sv | 38 +++
 rtl/pipeline_hazard_controller.sv | 124 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// ID-stage request and hazard-control response bundle for pipeline_hazard_controller.
// The master side is the core top (ID decode plus memory status); the slave side is the controller.
interface pipeline_hazard_controller_if #(
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned DEPTH      = 3
);
    localparam int unsigned SEL_W = $clog2(DEPTH + 1);

    logic [REG_ADDR_W-1:0] id_src1;
    logic [REG_ADDR_W-1:0] id_src2;
    logic                  id_two_src;
    logic                  id_ignore_hazard;
    logic                  id_wb_en;
    logic [REG_ADDR_W-1:0] id_dest;
    logic                  id_mem_read;
    logic                  flush;
    logic                  mem_ready;

    logic                  freeze_front;
    logic                  bubble;
    logic                  freeze_all;
    logic [SEL_W-1:0]      fwd_sel1;
    logic [SEL_W-1:0]      fwd_sel2;
    logic [15:0]           stall_count;
    logic [DEPTH-1:0]      slot_valid;

    modport master (
        output id_src1, id_src2, id_two_src, id_ignore_hazard, id_wb_en, id_dest, id_mem_read,
        output flush, mem_ready,
        input  freeze_front, bubble, freeze_all, fwd_sel1, fwd_sel2, stall_count, slot_valid
    );

    modport slave (
        input  id_src1, id_src2, id_two_src, id_ignore_hazard, id_wb_en, id_dest, id_mem_read,
        input  flush, mem_ready,
        output freeze_front, bubble, freeze_all, fwd_sel1, fwd_sel2, stall_count, slot_valid
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Scoreboard-based hazard controller: stall/bubble, operand-forward selects and a global freeze
// while a load waits on the data memory.
module pipeline_hazard_controller #(
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned DEPTH      = 3,
    parameter bit          FWD_EN     = 1'b1,
    parameter int unsigned MEM_SLOT   = 1
) (
    input logic                         clk,
    input logic                         rst,
    pipeline_hazard_controller_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic                  valid;
        logic                  wb_en;
        logic [REG_ADDR_W-1:0] dest;
        logic                  is_load;
    } slot_t;

    slot_t [DEPTH-1:0] slot_q, slot_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    logic [DEPTH-1:0]  match1, match2;
    logic              mem_wait;
    logic              hazard;
    logic              front_hold;
    logic              bubble_int;
    logic [SEL_W-1:0]  sel1, sel2;

    assign mem_wait   = slot_q[MEM_SLOT].valid && slot_q[MEM_SLOT].is_load && !bus.mem_ready;
    assign front_hold = mem_wait || (hazard && !bus.flush);
    // A pending flush is held off while frozen; ID stays frozen so it is seen again later.
    assign bubble_int = !mem_wait && (hazard || bus.flush);

    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            match1[k] = slot_q[k].valid && slot_q[k].wb_en && (slot_q[k].dest == bus.id_src1)
                        && !bus.id_ignore_hazard;
            match2[k] = slot_q[k].valid && slot_q[k].wb_en && (slot_q[k].dest == bus.id_src2)
                        && !bus.id_ignore_hazard && bus.id_two_src;
        end
    end

    // Walk oldest to youngest so the youngest matching producer sets the select last.
    always_comb begin
        hazard = 1'b0;
        sel1   = '0;
        sel2   = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (FWD_EN) begin
                if ((match1[k] || match2[k]) && slot_q[k].is_load && (k < int'(MEM_SLOT))) begin
                    hazard = 1'b1;
                end
                if (match1[k]) begin
                    sel1 = SEL_W'(k + 1);
                end
                if (match2[k]) begin
                    sel2 = SEL_W'(k + 1);
                end
            end else if ((match1[k] || match2[k]) && (k < int'(DEPTH) - 1)) begin
                // The last slot writes back this cycle and the regfile is write-first.
                hazard = 1'b1;
            end
        end
        if (hazard) begin
            sel1 = '0;
            sel2 = '0;
        end
    end

    always_comb begin
        slot_d      = slot_q;
        stall_cnt_d = stall_cnt_q;
        if (!mem_wait) begin
            for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
                slot_d[k] = slot_q[k-1];
            end
            if (bubble_int) begin
                slot_d[0] = '0;
            end else begin
                slot_d[0] = '{valid: 1'b1, wb_en: bus.id_wb_en, dest: bus.id_dest,
                              is_load: bus.id_mem_read};
            end
        end
        if (front_hold && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            slot_q      <= slot_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        bus.freeze_all   = 1'b0;
        bus.freeze_front = 1'b0;
        bus.bubble       = 1'b0;
        bus.fwd_sel1     = '0;
        bus.fwd_sel2     = '0;
        bus.stall_count  = '0;
        bus.slot_valid   = '0;
        if (!rst) begin
            bus.freeze_all   = mem_wait;
            bus.freeze_front = front_hold;
            bus.bubble       = bubble_int;
            bus.fwd_sel1     = sel1;
            bus.fwd_sel2     = sel2;
            bus.stall_count  = stall_cnt_q;
            for (int k = 0; k < int'(DEPTH); k++) begin
                bus.slot_valid[k] = slot_q[k].valid;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: a forwarding and a stall-only instance share
// stimulus, each checked every cycle against an in-flight-instruction model plus literal pins.
module tb_pipeline_hazard_controller;
    localparam int D  = 3;
    localparam int MS = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if #(.REG_ADDR_W(4), .DEPTH(D)) bf ();
    pipeline_hazard_controller_if #(.REG_ADDR_W(4), .DEPTH(D)) bs ();

    pipeline_hazard_controller #(
        .REG_ADDR_W(4), .DEPTH(D), .FWD_EN(1'b1), .MEM_SLOT(MS)
    ) dut_f (
        .clk(clk), .rst(rst), .bus(bf.slave)
    );

    pipeline_hazard_controller #(
        .REG_ADDR_W(4), .DEPTH(D), .FWD_EN(1'b0), .MEM_SLOT(MS)
    ) dut_s (
        .clk(clk), .rst(rst), .bus(bs.slave)
    );

    typedef struct { bit v; bit wb; bit [3:0] dest; bit ld; } ent_t;
    typedef ent_t q_t[$];
    typedef struct { bit ff; bit bub; bit fa; int s1; int s2; int sc; bit [D-1:0] sv; } exp_t;

    int   errors = 0;
    int   checks = 0;
    q_t   pf, ps;
    int   cf = 0, cs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t zero_e();
        exp_t e;
        e = '{ff: 1'b0, bub: 1'b0, fa: 1'b0, s1: 0, s2: 0, sc: 0, sv: '0};
        return e;
    endfunction

    // Expected outputs from the in-flight instruction list (index 0 = youngest, in EXE).
    function automatic exp_t model_eval(input bit fwd, input q_t p, input int cnt);
        exp_t       e;
        bit         haz;
        int         y;
        logic [3:0] src;
        e    = zero_e();
        e.sc = cnt;
        for (int k = 0; k < D; k++) e.sv[k] = p[k].v;
        if (p[MS].v && p[MS].ld && !bf.mem_ready) begin
            e.fa = 1'b1;
            e.ff = 1'b1;
            return e;
        end
        haz = 1'b0;
        for (int s = 1; s <= 2; s++) begin
            src = (s == 1) ? bf.id_src1 : bf.id_src2;
            if (bf.id_ignore_hazard || (s == 2 && !bf.id_two_src)) continue;
            y = -1;
            for (int k = 0; k < D; k++) begin
                if (p[k].v && p[k].wb && p[k].dest == src) begin
                    if (y < 0) y = k;
                    if (fwd ? (p[k].ld && k < MS) : (k < D - 1)) haz = 1'b1;
                end
            end
            if (fwd && y >= 0) begin
                if (s == 1) e.s1 = y + 1;
                else        e.s2 = y + 1;
            end
        end
        if (haz) begin
            e.s1 = 0;
            e.s2 = 0;
        end
        e.ff  = haz && !bf.flush;
        e.bub = haz || bf.flush;
        return e;
    endfunction

    function automatic q_t advance(input q_t p, input bit bub);
        ent_t n;
        q_t   r;
        r = p;
        n = '{v: !bub, wb: bf.id_wb_en, dest: bf.id_dest, ld: bf.id_mem_read};
        if (bub) n = '{v: 1'b0, wb: 1'b0, dest: 4'd0, ld: 1'b0};
        void'(r.pop_back());
        r.push_front(n);
        return r;
    endfunction

    task automatic compare(input string tag, input exp_t e, input logic ff, input logic bub,
                           input logic fa, input logic [1:0] s1, input logic [1:0] s2,
                           input logic [15:0] sc, input logic [D-1:0] sv);
        chk({tag, ".freeze_front"}, 32'(ff), 32'(e.ff));
        chk({tag, ".bubble"}, 32'(bub), 32'(e.bub));
        chk({tag, ".freeze_all"}, 32'(fa), 32'(e.fa));
        chk({tag, ".stall_count"}, 32'(sc), 32'(e.sc));
        chk({tag, ".slot_valid"}, 32'(sv), 32'(e.sv));
        if (!e.fa) begin
            chk({tag, ".fwd_sel1"}, 32'(s1), 32'(e.s1));
            chk({tag, ".fwd_sel2"}, 32'(s2), 32'(e.s2));
        end
    endtask

    // Inputs change only just after posedge, so negedge values are those the next edge samples.
    initial begin
        exp_t ef, es;
        for (int k = 0; k < D; k++) begin
            pf.push_back('{v: 1'b0, wb: 1'b0, dest: 4'd0, ld: 1'b0});
            ps.push_back('{v: 1'b0, wb: 1'b0, dest: 4'd0, ld: 1'b0});
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                ef = zero_e();
                es = zero_e();
            end else begin
                ef = model_eval(1'b1, pf, cf);
                es = model_eval(1'b0, ps, cs);
            end
            compare("fwd", ef, bf.freeze_front, bf.bubble, bf.freeze_all, bf.fwd_sel1,
                    bf.fwd_sel2, bf.stall_count, bf.slot_valid);
            compare("stl", es, bs.freeze_front, bs.bubble, bs.freeze_all, bs.fwd_sel1,
                    bs.fwd_sel2, bs.stall_count, bs.slot_valid);
            if (rst) begin
                for (int k = 0; k < D; k++) begin
                    pf[k].v = 1'b0;
                    ps[k].v = 1'b0;
                end
                cf = 0;
                cs = 0;
            end else begin
                if ((ef.ff || ef.fa) && cf < 65535) cf++;
                if ((es.ff || es.fa) && cs < 65535) cs++;
                if (!ef.fa) pf = advance(pf, ef.bub);
                if (!es.fa) ps = advance(ps, es.bub);
            end
        end
    end

    task automatic drive(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                         input logic ign, input logic wb, input logic [3:0] dst,
                         input logic ld, input logic fl, input logic mr);
        bf.id_src1 = s1;  bs.id_src1 = s1;
        bf.id_src2 = s2;  bs.id_src2 = s2;
        bf.id_two_src = two;  bs.id_two_src = two;
        bf.id_ignore_hazard = ign;  bs.id_ignore_hazard = ign;
        bf.id_wb_en = wb;  bs.id_wb_en = wb;
        bf.id_dest = dst;  bs.id_dest = dst;
        bf.id_mem_read = ld;  bs.id_mem_read = ld;
        bf.flush = fl;  bs.flush = fl;
        bf.mem_ready = mr;  bs.mem_ready = mr;
    endtask

    task automatic nop(input logic mr);
        drive(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, mr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        tick(); nop(1'b1);
        tick();
        tick();
    endtask

    initial begin
        nop(1'b1);
        repeat (2) tick();
        #3;
        chk("rst.slot_valid", 32'(bf.slot_valid), 32'd0);
        chk("rst.stall_count", 32'(bs.stall_count), 32'd0);

        // ADD R1,R2,R3 then ADD R2,R1,R3 held for three cycles
        tick(); rst = 1'b0;
        drive(4'd2, 4'd3, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1); #3;
        chk("s1a.fwd.freeze_front", 32'(bf.freeze_front), 32'd0);
        tick(); drive(4'd1, 4'd3, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1); #3;
        chk("s1b.fwd.freeze_front", 32'(bf.freeze_front), 32'd0);
        chk("s1b.fwd.fwd_sel1", 32'(bf.fwd_sel1), 32'd1);
        chk("s3b.stl.freeze_front", 32'(bs.freeze_front), 32'd1);
        chk("s3b.stl.bubble", 32'(bs.bubble), 32'd1);
        tick(); #3;
        chk("s1c.fwd.fwd_sel1", 32'(bf.fwd_sel1), 32'd2);
        chk("s3c.stl.freeze_front", 32'(bs.freeze_front), 32'd1);
        tick(); #3;
        chk("s3d.stl.freeze_front", 32'(bs.freeze_front), 32'd0);
        chk("s3d.stl.fwd_sel1", 32'(bs.fwd_sel1), 32'd0);
        chk("s3d.stl.stall_count", 32'(bs.stall_count), 32'd2);
        chk("s1d.fwd.stall_count", 32'(bf.stall_count), 32'd0);
        chk("s1d.fwd.fwd_sel1", 32'(bf.fwd_sel1), 32'd3);
        drain();

        // LDR R4 then ADD R5,R4,R4 (load-use)
        tick(); drive(4'd9, 4'd0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 1'b1); #3;
        tick(); drive(4'd4, 4'd4, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1); #3;
        chk("s2f.fwd.freeze_front", 32'(bf.freeze_front), 32'd1);
        chk("s2f.fwd.bubble", 32'(bf.bubble), 32'd1);
        chk("s2f.fwd.fwd_sel1", 32'(bf.fwd_sel1), 32'd0);
        tick(); #3;
        chk("s2g.fwd.freeze_front", 32'(bf.freeze_front), 32'd0);
        chk("s2g.fwd.bubble", 32'(bf.bubble), 32'd0);
        chk("s2g.fwd.fwd_sel1", 32'(bf.fwd_sel1), 32'd2);
        chk("s2g.fwd.fwd_sel2", 32'(bf.fwd_sel2), 32'd2);
        chk("s2g.fwd.stall_count", 32'(bf.stall_count), 32'd1);
        drain();

        // LDR R7 reaches MEM with mem_ready low for three cycles
        tick(); drive(4'd9, 4'd0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1); #3;
        tick(); nop(1'b1); #3;
        tick(); nop(1'b0); #3;
        chk("s4k.fwd.freeze_all", 32'(bf.freeze_all), 32'd1);
        chk("s4k.fwd.freeze_front", 32'(bf.freeze_front), 32'd1);
        chk("s4k.fwd.bubble", 32'(bf.bubble), 32'd0);
        chk("s4k.fwd.slot_valid", 32'(bf.slot_valid), 32'd7);
        tick(); #3;
        chk("s4l.fwd.slot_valid", 32'(bf.slot_valid), 32'd7);
        tick(); #3;
        chk("s4m.stl.freeze_all", 32'(bs.freeze_all), 32'd1);
        tick(); nop(1'b1); #3;
        chk("s4n.fwd.freeze_all", 32'(bf.freeze_all), 32'd0);
        chk("s4n.fwd.stall_count", 32'(bf.stall_count), 32'd4);
        chk("s4n.stl.stall_count", 32'(bs.stall_count), 32'd7);
        drain();

        // Hazard and flush together
        tick(); drive(4'd9, 4'd0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1); #3;
        tick(); drive(4'd1, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b1); #3;
        chk("s5q.fwd.freeze_front", 32'(bf.freeze_front), 32'd0);
        chk("s5q.fwd.bubble", 32'(bf.bubble), 32'd1);
        chk("s5q.stl.freeze_front", 32'(bs.freeze_front), 32'd0);
        chk("s5q.stl.bubble", 32'(bs.bubble), 32'd1);
        tick(); nop(1'b1); #3;
        chk("s5r.fwd.slot0", 32'(bf.slot_valid[0]), 32'd0);
        chk("s5r.stl.slot0", 32'(bs.slot_valid[0]), 32'd0);
        chk("s5r.fwd.stall_count", 32'(bf.stall_count), 32'd4);
        drain();

        // Flush arriving while a load waits on memory
        tick(); drive(4'd9, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1); #3;
        tick(); nop(1'b1); #3;
        tick(); drive(4'd5, 4'd0, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0); #3;
        chk("s5u.fwd.freeze_all", 32'(bf.freeze_all), 32'd1);
        chk("s5u.fwd.bubble", 32'(bf.bubble), 32'd0);
        tick(); #3;
        chk("s5v.fwd.bubble", 32'(bf.bubble), 32'd0);
        tick(); drive(4'd5, 4'd0, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0, 1'b1, 1'b1); #3;
        chk("s5w.fwd.freeze_all", 32'(bf.freeze_all), 32'd0);
        chk("s5w.fwd.bubble", 32'(bf.bubble), 32'd1);
        chk("s5w.fwd.freeze_front", 32'(bf.freeze_front), 32'd0);
        tick(); nop(1'b1); #3;
        chk("s5x.fwd.slot0", 32'(bf.slot_valid[0]), 32'd0);
        drain();

        // Reset during a load-use stall
        tick(); drive(4'd9, 4'd0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 1'b1); #3;
        tick(); rst = 1'b1;
        drive(4'd4, 4'd4, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1); #3;
        chk("s6r.fwd.freeze_front", 32'(bf.freeze_front), 32'd0);
        chk("s6r.fwd.bubble", 32'(bf.bubble), 32'd0);
        chk("s6r.fwd.stall_count", 32'(bf.stall_count), 32'd0);
        tick(); rst = 1'b0; #3;
        chk("s6a.fwd.slot_valid", 32'(bf.slot_valid), 32'd0);
        chk("s6a.fwd.freeze_front", 32'(bf.freeze_front), 32'd0);
        chk("s6a.fwd.bubble", 32'(bf.bubble), 32'd0);
        chk("s6a.fwd.fwd_sel1", 32'(bf.fwd_sel1), 32'd0);
        chk("s6a.fwd.stall_count", 32'(bf.stall_count), 32'd0);
        chk("s6a.stl.freeze_front", 32'(bs.freeze_front), 32'd0);

        // Long memory wait drives stall_count into saturation
        tick(); drive(4'd9, 4'd0, 1'b0, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 1'b1); #3;
        tick(); nop(1'b1); #3;
        tick(); nop(1'b0);
        repeat (65534) tick();
        #3;
        chk("sat.fwd.stall_count_pre", 32'(bf.stall_count), 32'd65534);
        repeat (6) tick();
        #3;
        chk("sat.fwd.stall_count", 32'(bf.stall_count), 32'hFFFF);
        chk("sat.stl.stall_count", 32'(bs.stall_count), 32'hFFFF);
        tick(); nop(1'b1); #3;
        chk("sat.fwd.freeze_all", 32'(bf.freeze_all), 32'd0);
        chk("sat.fwd.stall_hold", 32'(bf.stall_count), 32'hFFFF);
        tick(); #3;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
